// File: rtl/spi_arb_if.sv
// Bus bundle between the two requesters, the arbiter and the shared SPI engine.
// The arbiter takes the slave view; requesters and engine together form the master view.
interface spi_arb_if;
    localparam int unsigned DATA_W = 16;

    logic              req0;
    logic [DATA_W-1:0] cmd0;
    logic              req1;
    logic [DATA_W-1:0] cmd1;
    logic              eng_wrt;
    logic [DATA_W-1:0] eng_wt_data;
    logic              eng_done;
    logic [DATA_W-1:0] eng_rd_data;
    logic              sel;
    logic              rdy0;
    logic              rdy1;
    logic [DATA_W-1:0] rsp;
    logic              tmo;

    modport slave (
        input  req0, cmd0, req1, cmd1, eng_done, eng_rd_data,
        output eng_wrt, eng_wt_data, sel, rdy0, rdy1, rsp, tmo
    );

    modport master (
        output req0, cmd0, req1, cmd1, eng_done, eng_rd_data,
        input  eng_wrt, eng_wt_data, sel, rdy0, rdy1, rsp, tmo
    );
endinterface

// File: rtl/spi_arb.sv
// Round-robin arbiter/sequencer sharing one SPI engine between the gyro (0) and A2D (1),
// with an SS_n idle gap after every transaction and a done-timeout watchdog.
module spi_arb #(
    parameter int unsigned GAP_CYC = 8,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic     clk,
    input  logic     rst,
    spi_arb_if.slave bus
);
    localparam int unsigned DATA_W  = 16;
    localparam int unsigned CNT_MAX = (TIMEOUT > GAP_CYC) ? TIMEOUT : GAP_CYC;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {IDLE, ISSUE, BUSY, RESP, GAP} state_t;

    state_t            state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n;
    logic              last_gnt, last_gnt_n;
    logic              sel_q, sel_n;
    logic [DATA_W-1:0] wt_q, wt_n;
    logic              wrt_q, wrt_n;
    logic              rdy0_q, rdy0_n;
    logic              rdy1_q, rdy1_n;
    logic [DATA_W-1:0] rsp_q, rsp_n;
    logic              tmo_q, tmo_n;
    logic              gnt;

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            last_gnt <= 1'b1;
            sel_q    <= 1'b0;
            wt_q     <= '0;
            wrt_q    <= 1'b0;
            rdy0_q   <= 1'b0;
            rdy1_q   <= 1'b0;
            rsp_q    <= '0;
            tmo_q    <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            last_gnt <= last_gnt_n;
            sel_q    <= sel_n;
            wt_q     <= wt_n;
            wrt_q    <= wrt_n;
            rdy0_q   <= rdy0_n;
            rdy1_q   <= rdy1_n;
            rsp_q    <= rsp_n;
            tmo_q    <= tmo_n;
        end
    end

    // Next state and next values of the output registers
    always_comb begin
        state_n    = state;
        cnt_n      = cnt;
        last_gnt_n = last_gnt;
        sel_n      = sel_q;
        wt_n       = wt_q;
        wrt_n      = 1'b0;
        rdy0_n     = 1'b0;
        rdy1_n     = 1'b0;
        rsp_n      = rsp_q;
        tmo_n      = 1'b0;
        gnt        = 1'b0;

        case (state)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    // On a tie the requester that did not win last time gets the engine
                    gnt        = (bus.req0 && bus.req1) ? ~last_gnt : bus.req1;
                    sel_n      = gnt;
                    last_gnt_n = gnt;
                    wt_n       = gnt ? bus.cmd1 : bus.cmd0;
                    wrt_n      = 1'b1;
                    state_n    = ISSUE;
                end
            end
            ISSUE: begin
                cnt_n   = '0;
                state_n = BUSY;
            end
            BUSY: begin
                // A done on the final watchdog cycle still delivers real data
                if (bus.eng_done) begin
                    rsp_n   = bus.eng_rd_data;
                    rdy0_n  = ~sel_q;
                    rdy1_n  = sel_q;
                    state_n = RESP;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    rsp_n   = {DATA_W{1'b1}};
                    tmo_n   = 1'b1;
                    rdy0_n  = ~sel_q;
                    rdy1_n  = sel_q;
                    state_n = RESP;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            RESP: begin
                cnt_n   = '0;
                state_n = GAP;
            end
            GAP: begin
                if (cnt == CNT_W'(GAP_CYC - 1)) begin
                    state_n = IDLE;
                end else begin
                    cnt_n = cnt + CNT_W'(1);
                end
            end
            default: state_n = IDLE;
        endcase
    end

    assign bus.eng_wrt     = wrt_q;
    assign bus.eng_wt_data = wt_q;
    assign bus.sel         = sel_q;
    assign bus.rdy0        = rdy0_q;
    assign bus.rdy1        = rdy1_q;
    assign bus.rsp         = rsp_q;
    assign bus.tmo         = tmo_q;
endmodule

// File: tb/tb_spi_arb.sv
// Scoreboard bench for spi_arb: expected issues/responses are queued when stimulus is
// driven and compared as the arbiter produces eng_wrt and rdy pulses.
module tb_spi_arb;
    localparam int GAP_CYC = 8;
    localparam int TIMEOUT = 1024;

    typedef struct packed {
        logic        s;
        logic [15:0] d;
    } iss_t;

    typedef struct packed {
        logic        s;
        logic [15:0] d;
        logic        t;
    } rsp_t;

    logic clk = 1'b0;
    logic rst;
    spi_arb_if bus ();

    spi_arb #(.GAP_CYC(GAP_CYC), .TIMEOUT(TIMEOUT)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    int last_wrt_cyc = -1;
    int done_cyc     = -1000;
    int tmo_rdy_cyc  = 0;
    int rdy_cyc [2];
    int eng_delay = 0;
    int eng_cnt   = 0;
    logic [15:0] eng_key  = '0;
    logic [15:0] eng_data = '0;
    int t3w;

    iss_t iss_q[$];
    rsp_t rsp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) $display("FAIL %s: got %0h want %0h (cycle %0d)", tag, obs, exp, cyc);
        else n_pass++;
    endtask

    task automatic exp_iss(input logic s, input logic [15:0] d);
        iss_t e;
        e.s = s;
        e.d = d;
        iss_q.push_back(e);
    endtask

    task automatic exp_rsp(input logic s, input logic [15:0] d, input logic t);
        rsp_t e;
        e.s = s;
        e.d = d;
        e.t = t;
        rsp_q.push_back(e);
    endtask

    // One clock: sample outputs 1ns after the edge, score them, then step the engine model
    task automatic tick();
        iss_t ie;
        rsp_t re;
        bit   keep;
        @(posedge clk);
        #1;
        cyc++;
        if (bus.eng_wrt) begin
            if (iss_q.size() == 0) begin
                chk("wrt_spur", 32'(bus.eng_wrt), 32'd0);
            end else begin
                ie = iss_q.pop_front();
                chk("wt_data", 32'(bus.eng_wt_data), 32'(ie.d));
                chk("wrt_sel", 32'(bus.sel), 32'(ie.s));
            end
            if (last_wrt_cyc >= 0)
                chk("wrt_gap", 32'((cyc - last_wrt_cyc) >= (4 + GAP_CYC)), 32'd1);
            last_wrt_cyc = cyc;
        end
        if (bus.rdy0 || bus.rdy1) begin
            if (rsp_q.size() == 0) begin
                chk("rdy_spur", 32'({bus.rdy1, bus.rdy0}), 32'd0);
            end else begin
                re = rsp_q.pop_front();
                chk("rdy_who", 32'({bus.rdy1, bus.rdy0}), re.s ? 32'd2 : 32'd1);
                chk("rsp", 32'(bus.rsp), 32'(re.d));
                chk("tmo", 32'(bus.tmo), 32'(re.t));
                if (!re.t) chk("lat_rdy", 32'(cyc - done_cyc), 32'd1);
                else tmo_rdy_cyc = cyc;
                rdy_cyc[int'(re.s)] = cyc;
                keep = 1'b0;
                foreach (iss_q[i]) if (iss_q[i].s == re.s) keep = 1'b1;
                if (!keep) begin
                    if (re.s) bus.req1 = 1'b0;
                    else      bus.req0 = 1'b0;
                end
            end
        end else if (bus.tmo) begin
            chk("tmo_spur", 32'(bus.tmo), 32'd0);
        end
        bus.eng_done = 1'b0;
        if (eng_cnt == 1) begin
            bus.eng_done    = 1'b1;
            bus.eng_rd_data = eng_data;
            done_cyc        = cyc;
        end
        if (eng_cnt > 0) eng_cnt--;
        if (bus.eng_wrt && eng_delay > 0) begin
            eng_cnt  = eng_delay;
            eng_data = bus.eng_wt_data ^ eng_key;
        end
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while (rsp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        chk({tag, "_drain"}, 32'(rsp_q.size()), 32'd0);
        repeat (GAP_CYC + 4) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        last_wrt_cyc = -1;
        eng_cnt      = 0;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        bus.cmd0 = '0;
        bus.cmd1 = '0;
        bus.eng_done    = 1'b0;
        bus.eng_rd_data = '0;
        rdy_cyc[0] = 0;
        rdy_cyc[1] = 0;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        chk("rst_wrt", 32'(bus.eng_wrt), 32'd0);
        chk("rst_wt",  32'(bus.eng_wt_data), 32'd0);
        chk("rst_sel", 32'(bus.sel), 32'd0);
        chk("rst_rdy", 32'({bus.rdy1, bus.rdy0}), 32'd0);
        chk("rst_rsp", 32'(bus.rsp), 32'd0);
        chk("rst_tmo", 32'(bus.tmo), 32'd0);

        // Single gyro transaction; cmd change after grant must not reach the engine
        eng_delay = 3;
        eng_key   = 16'hA500 ^ 16'h1234;
        exp_iss(1'b0, 16'hA500);
        exp_rsp(1'b0, 16'h1234, 1'b0);
        bus.cmd0 = 16'hA500;
        bus.req0 = 1'b1;
        tick();
        chk("t1_lat", 32'(bus.eng_wrt), 32'd1);
        bus.cmd0 = 16'h0BAD;
        tick();
        chk("t1_latch", 32'(bus.eng_wt_data), 32'hA500);
        drain("t1", 100);

        // Both requesting: strict alternation starting with requester 0
        do_reset();
        eng_delay = 20;
        eng_key   = 16'h00FF;
        exp_iss(1'b0, 16'h0100); exp_iss(1'b1, 16'h0200);
        exp_iss(1'b0, 16'h0100); exp_iss(1'b1, 16'h0200);
        exp_rsp(1'b0, 16'h01FF, 1'b0); exp_rsp(1'b1, 16'h02FF, 1'b0);
        exp_rsp(1'b0, 16'h01FF, 1'b0); exp_rsp(1'b1, 16'h02FF, 1'b0);
        bus.cmd0 = 16'h0100;
        bus.cmd1 = 16'h0200;
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        drain("t2", 400);

        // Watchdog abort on requester 1, then requester 0 waits out the gap
        eng_delay = 0;
        exp_iss(1'b1, 16'h8F00);
        exp_rsp(1'b1, 16'hFFFF, 1'b1);
        bus.cmd1 = 16'h8F00;
        bus.req1 = 1'b1;
        tick();
        chk("t3_wrt", 32'(bus.eng_wrt), 32'd1);
        t3w = last_wrt_cyc;
        eng_delay = 2;
        eng_key   = 16'h1111;
        exp_iss(1'b0, 16'h0300);
        exp_rsp(1'b0, 16'h1211, 1'b0);
        bus.cmd0 = 16'h0300;
        bus.req0 = 1'b1;
        drain("t3", 2000);
        chk("t3_tmo_lat", 32'(tmo_rdy_cyc - t3w), 32'(TIMEOUT + 1));
        chk("t3_regrant", 32'(last_wrt_cyc - tmo_rdy_cyc), 32'(GAP_CYC + 2));

        // Stray done while idle is ignored
        bus.eng_done    = 1'b1;
        bus.eng_rd_data = 16'hBEEF;
        done_cyc        = cyc;
        tick();
        tick();
        chk("t4_idle_rsp", 32'(bus.rsp), 32'h1211);
        chk("t4_idle_rdy", 32'({bus.rdy1, bus.rdy0}), 32'd0);

        // Done on the exact watchdog cycle wins over the timeout
        eng_delay = TIMEOUT;
        eng_key   = 16'h0400 ^ 16'h5555;
        exp_iss(1'b0, 16'h0400);
        exp_rsp(1'b0, 16'h5555, 1'b0);
        bus.cmd0 = 16'h0400;
        bus.req0 = 1'b1;
        drain("t4", 2000);

        // Reset mid-BUSY aborts silently; held request is re-issued right away
        eng_delay = 0;
        exp_iss(1'b0, 16'h0500);
        bus.cmd0 = 16'h0500;
        bus.req0 = 1'b1;
        repeat (4) tick();
        rst       = 1'b1;
        eng_delay = 2;
        eng_key   = 16'h0F0F;
        tick();
        rst = 1'b0;
        last_wrt_cyc = -1;
        chk("t5_sel", 32'(bus.sel), 32'd0);
        chk("t5_rsp", 32'(bus.rsp), 32'd0);
        chk("t5_rdy", 32'(bus.rdy0), 32'd0);
        chk("t5_wrt", 32'(bus.eng_wrt), 32'd0);
        exp_iss(1'b0, 16'h0500);
        exp_rsp(1'b0, 16'h0A0F, 1'b0);
        tick();
        chk("t5_rewrt", 32'(bus.eng_wrt), 32'd1);
        drain("t5", 100);

        // Owner drops req mid-transaction; req1 raised during BUSY waits for IDLE
        eng_delay = 10;
        eng_key   = 16'h00AA;
        exp_iss(1'b0, 16'h0600);
        exp_rsp(1'b0, 16'h06AA, 1'b0);
        bus.cmd0 = 16'h0600;
        bus.req0 = 1'b1;
        repeat (3) tick();
        bus.req0 = 1'b0;
        tick();
        exp_iss(1'b1, 16'h0700);
        exp_rsp(1'b1, 16'h07AA, 1'b0);
        bus.cmd1 = 16'h0700;
        bus.req1 = 1'b1;
        drain("t6", 300);
        chk("t6_gnt", 32'(last_wrt_cyc - rdy_cyc[0]), 32'(GAP_CYC + 2));
        chk("iss_q_empty", 32'(iss_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
